// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: main/side/walk state machine with a per-phase
// second counter; every output is a register loaded on the same edge as the state.
module traffic_phase_controller #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       tick_1hz,
  input  logic       traffic_sensor_sync,
  input  logic       walk_request_sync,
  input  logic       reprogram_sync,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk_lamp,
  output logic [2:0] phase,
  output logic [3:0] remaining
);

  typedef enum logic [2:0] {
    MAIN_G1 = 3'd0,
    MAIN_G2 = 3'd1,
    MAIN_Y  = 3'd2,
    WALK    = 3'd3,
    SIDE_G1 = 3'd4,
    SIDE_G2 = 3'd5,
    SIDE_Y  = 3'd6
  } state_t;

  localparam logic [3:0] T_BASE_C = 4'(T_BASE);
  localparam logic [3:0] T_EXT_C  = 4'(T_EXT);
  localparam logic [3:0] T_YEL_C  = 4'(T_YEL);

  state_t     state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic       walk_pending_q, walk_pending_d;
  logic [6:0] lamps_d;

  // Lamp pattern {main[2:0], side[2:0], walk}; lamp vectors are {red, yellow, green}.
  function automatic logic [6:0] decode_lamps(input state_t s);
    logic [6:0] l;
    case (s)
      MAIN_G1, MAIN_G2: l = {3'b001, 3'b100, 1'b0};
      MAIN_Y:           l = {3'b010, 3'b100, 1'b0};
      WALK:             l = {3'b100, 3'b100, 1'b1};
      SIDE_G1, SIDE_G2: l = {3'b100, 3'b001, 1'b0};
      SIDE_Y:           l = {3'b100, 3'b010, 1'b0};
      default:          l = {3'b001, 3'b100, 1'b0};
    endcase
    return l;
  endfunction

  // Next-state, interval reload and pedestrian latch.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    walk_pending_d = walk_pending_q | (walk_request_sync & (state_q != WALK));
    if (reprogram_sync || (3'(state_q) == 3'd7)) begin
      state_d     = MAIN_G1;
      remaining_d = T_BASE_C;
    end else if (tick_1hz) begin
      if (remaining_q > 4'd1) begin
        remaining_d = remaining_q - 4'd1;
      end else begin
        // Expiry: the sensor only matters on this clock.
        case (state_q)
          MAIN_G1: begin
            state_d     = MAIN_G2;
            remaining_d = traffic_sensor_sync ? T_EXT_C : T_BASE_C;
          end
          MAIN_G2: begin
            state_d     = MAIN_Y;
            remaining_d = T_YEL_C;
          end
          MAIN_Y: begin
            if (walk_pending_q || walk_request_sync) begin
              state_d        = WALK;
              remaining_d    = T_EXT_C;
              walk_pending_d = 1'b0;
            end else begin
              state_d     = SIDE_G1;
              remaining_d = T_BASE_C;
            end
          end
          WALK: begin
            state_d     = SIDE_G1;
            remaining_d = T_BASE_C;
          end
          SIDE_G1: begin
            if (traffic_sensor_sync) begin
              state_d     = SIDE_G2;
              remaining_d = T_EXT_C;
            end else begin
              state_d     = SIDE_Y;
              remaining_d = T_YEL_C;
            end
          end
          SIDE_G2: begin
            state_d     = SIDE_Y;
            remaining_d = T_YEL_C;
          end
          SIDE_Y: begin
            state_d     = MAIN_G1;
            remaining_d = T_BASE_C;
          end
          default: begin
            state_d     = MAIN_G1;
            remaining_d = T_BASE_C;
          end
        endcase
      end
    end else begin
      remaining_d = remaining_q;
    end
    lamps_d = decode_lamps(state_d);
  end

  // State, timer, pending latch and lamp registers.
  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      state_q        <= MAIN_G1;
      remaining_q    <= T_BASE_C;
      walk_pending_q <= 1'b0;
      main_lamp      <= 3'b001;
      side_lamp      <= 3'b100;
      walk_lamp      <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      walk_pending_q <= walk_pending_d;
      main_lamp      <= lamps_d[6:4];
      side_lamp      <= lamps_d[3:1];
      walk_lamp      <= lamps_d[0];
    end
  end

  assign phase     = 3'(state_q);
  assign remaining = remaining_q;

endmodule
